// File: rtl/rf_wr_sched_pkg.sv
// Shared sizing defaults and helpers for the register-file write scheduler.
package rf_wr_sched_pkg;

  localparam int RF_DW   = 16;
  localparam int RF_NREG = 8;
  localparam int RF_AW   = 3;
  localparam int RF_NREQ = 2;

  // Round-robin successor of requester g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rf_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rf_wr_sched_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wr_sched.sv
// Write-port scheduler for the clock-enabled register file: arbitrates requesters,
// registers a one-hot clk_en plus shared D bus, and tracks pending writes.
module rf_wr_sched
  import rf_wr_sched_pkg::*;
#(
  parameter int DW   = RF_DW,
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int NREQ = RF_NREQ
) (
  input  logic               clk_n,
  input  logic               rst_n,
  input  logic               sched_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREG-1:0]    rf_clk_en,
  output logic [DW-1:0]      rf_d,
  output logic [NREG-1:0]    pend,
  output logic               err_oor
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   r_ptr;
  logic [NREG-1:0] r_clk_en;
  logic [DW-1:0]   r_d;
  logic [NREG-1:0] r_pend;
  logic            r_err;

  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_ready;
  logic            w_xfer;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            w_in_range;
  logic [NREG-1:0] w_set;

  rf_wr_sched_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  // Reset is folded into ready so nothing is accepted while rst_n is low.
  assign w_ready = w_gnt & {NREQ{sched_en & rst_n}};
  assign w_xfer  = |w_ready;

  always_comb begin
    w_gidx = '0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_ready[i]) begin
        w_gidx = PW'(i);
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_in_range = (int'(w_addr) < NREG);
  assign w_ptr_nxt  = PW'(rr_next(int'(w_gidx), NREQ));

  always_comb begin
    w_set = '0;
    for (int k = 0; k < NREG; k++) begin
      if (w_xfer && w_in_range && (int'(w_addr) == k)) begin
        w_set[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_clk_en <= '0;
      r_d      <= '0;
      r_pend   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_clk_en <= w_set;
      r_err    <= w_xfer & ~w_in_range;
      // A write retiring this cycle clears its bit unless a new one to the same reg lands.
      r_pend   <= (r_pend & ~r_clk_en) | w_set;
      if (w_xfer) begin
        r_d   <= w_data;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign req_ready = w_ready;
  assign rf_clk_en = r_clk_en;
  assign rf_d      = r_d;
  assign pend      = r_pend;
  assign err_oor   = r_err;

endmodule

// File: tb/tb_rf_wr_sched.sv
// Scoreboard bench for rf_wr_sched: stimulus pushes expected writes, a monitor checks them.
module tb_rf_wr_sched;

  localparam int DW   = 16;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int NREQ = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sched_en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREG-1:0]    rf_clk_en;
  logic [DW-1:0]      rf_d;
  logic [NREG-1:0]    pend;
  logic               err_oor;

  always #5 clk = ~clk;

  rf_wr_sched #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW),
    .NREQ (NREQ)
  ) u_dut (
    .clk_n     (clk),
    .rst_n     (rst_n),
    .sched_en  (sched_en),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_clk_en (rf_clk_en),
    .rf_d      (rf_d),
    .pend      (pend),
    .err_oor   (err_oor)
  );

  typedef struct packed {
    logic [7:0]  en;
    logic [15:0] d;
    logic        err;
    logic [7:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   mon_on    = 1'b0;

  logic [DW-1:0] rf_model [NREG];

  always @(posedge clk) begin
    for (int k = 0; k < NREG; k++) begin
      if (rf_clk_en[k]) rf_model[k] <= rf_d;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic [1:0] exp_ready);
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(exp_ready));
    tick();
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [15:0] d0,
                       input logic [2:0] a1, input logic [15:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic push(input logic [7:0] en, input logic [15:0] d, input logic err,
                      input logic [7:0] pd);
    exp_t e;
    e.en   = en;
    e.d    = d;
    e.err  = err;
    e.pend = pd;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT drives a write or an error pulse, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on && ((rf_clk_en != '0) || err_oor)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {25'b0, err_oor, rf_clk_en}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_clk_en", 32'(rf_clk_en), 32'(e.en));
          if (!e.err) chk("mon_d", 32'(rf_d), 32'(e.d));
          chk("mon_err", 32'(err_oor), 32'(e.err));
          chk("mon_pend", 32'(pend), 32'(e.pend));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    sched_en = 1'b1;
    drive(2'b11, 3'd1, 16'h0a0a, 3'd2, 16'h0b0b);
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_clk_en", 32'(rf_clk_en), 32'h0);
    chk("rst_d", 32'(rf_d), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_err", 32'(err_oor), 32'h0);
    mon_on = 1'b1;
    tick();

    // release: pointer starts at req0
    rst_n = 1'b1;
    push(8'h02, 16'h0a0a, 1'b0, 8'h02);
    step("rst_first_grant", 2'b01);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    step("t1_idle0", 2'b00);
    step("t1_idle1", 2'b00);

    // single write, pointer now at req1 but only req0 valid
    drive(2'b01, 3'd3, 16'h1111, 3'd0, 16'h0);
    push(8'h08, 16'h1111, 1'b0, 8'h08);
    step("t2_grant", 2'b01);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);
    chk("t2_pend_n1", 32'(pend), 32'h08);
    tick();
    @(negedge clk);
    chk("t2_pend_n2", 32'(pend), 32'h00);
    chk("t2_clk_en_n2", 32'(rf_clk_en), 32'h00);
    tick();

    // contention, pointer at req1
    drive(2'b11, 3'd1, 16'h2222, 3'd2, 16'h4444);
    push(8'h04, 16'h4444, 1'b0, 8'h04);
    step("t3_g0", 2'b10);
    push(8'h02, 16'h2222, 1'b0, 8'h02);
    step("t3_g1", 2'b01);
    push(8'h04, 16'h4444, 1'b0, 8'h04);
    step("t3_g2", 2'b10);
    push(8'h02, 16'h2222, 1'b0, 8'h02);
    step("t3_g3", 2'b01);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    step("t3_idle0", 2'b00);
    step("t3_idle1", 2'b00);

    // same address back to back
    drive(2'b01, 3'd5, 16'h8888, 3'd5, 16'hcccc);
    push(8'h20, 16'h8888, 1'b0, 8'h20);
    step("t4_g0", 2'b01);
    drive(2'b10, 3'd5, 16'h8888, 3'd5, 16'hcccc);
    push(8'h20, 16'hcccc, 1'b0, 8'h20);
    step("t4_g1", 2'b10);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);
    chk("t4_pend_held", 32'(pend), 32'h20);
    tick();
    @(negedge clk);
    chk("t4_pend_clr", 32'(pend), 32'h00);
    chk("t4_reg5", 32'(rf_model[5]), 32'h0000cccc);
    tick();

    // out of range (NREG=6): addr 7 and addr 6
    drive(2'b10, 3'd0, 16'h0, 3'd4, 16'h5555);
    push(8'h10, 16'h5555, 1'b0, 8'h10);
    step("t5_g_in", 2'b10);
    drive(2'b01, 3'd7, 16'hffff, 3'd4, 16'h5555);
    push(8'h00, 16'hffff, 1'b1, 8'h00);
    step("t5_g_oor7", 2'b01);
    drive(2'b01, 3'd6, 16'heeee, 3'd0, 16'h0);
    push(8'h00, 16'heeee, 1'b1, 8'h00);
    step("t5_g_oor6", 2'b01);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);
    chk("t5_clk_en", 32'(rf_clk_en), 32'h00);
    chk("t5_pend", 32'(pend), 32'h00);
    tick();
    step("t5_idle", 2'b00);

    // sched_en gating, then reset mid-burst
    drive(2'b11, 3'd2, 16'h1234, 3'd4, 16'habcd);
    push(8'h10, 16'habcd, 1'b0, 8'h10);
    step("t6_g_a", 2'b10);
    sched_en = 1'b0;
    step("t6_off0", 2'b00);
    step("t6_off1", 2'b00);
    sched_en = 1'b1;
    push(8'h04, 16'h1234, 1'b0, 8'h04);
    step("t6_g_d", 2'b01);
    push(8'h10, 16'habcd, 1'b0, 8'h10);
    step("t6_g_e", 2'b10);
    rst_n = 1'b0;
    step("t6_rst_ready", 2'b00);
    @(negedge clk);
    chk("t6_rst_pend", 32'(pend), 32'h00);
    chk("t6_rst_clk_en", 32'(rf_clk_en), 32'h00);
    chk("t6_rst_d", 32'(rf_d), 32'h0000);
    chk("t6_rst_err", 32'(err_oor), 32'h0);
    tick();
    rst_n = 1'b1;
    push(8'h04, 16'h1234, 1'b0, 8'h04);
    step("t6_post_rst", 2'b01);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    step("t6_idle0", 2'b00);
    step("t6_idle1", 2'b00);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
